// File: rtl/mem_march_pkg.sv
// mem_march_pkg
//   Shared encodings for the march-test BIST initiator:
//   FSM states, march phases and the per-phase control word
//   (direction, ops per address, read presence, data selectors).
//   PAT_BASE is an alternating-01 word; the top slices it to WIDTH
//   to form the default background pattern.
package mem_march_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_P0 = 2'd0,
    PH_P1 = 2'd1,
    PH_P2 = 2'd2,
    PH_P3 = 2'd3
  } phase_e;

  typedef struct packed {
    logic       desc;      // address walks DEPTH-1 down to 0
    logic [1:0] op_cnt;    // operations per address (1 or 2)
    logic       has_read;  // op 0 is a read (a write follows when op_cnt == 2)
    logic       exp_inv;   // read expects ~PATTERN
    logic       wr_inv;    // write data is ~PATTERN
  } phase_cfg_t;

  localparam logic [63:0] PAT_BASE = {32{2'b01}};

  function automatic phase_cfg_t phase_cfg(input phase_e ph);
    phase_cfg_t c;
    case (ph)
      PH_P0:   c = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
      PH_P1:   c = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b1};
      PH_P2:   c = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
      PH_P3:   c = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
      default: c = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_march_checker.sv
// mem_march_checker
//   Compares read beats against the expected background, keeps a
//   saturating mismatch count and latches the address of the first
//   mismatch since the last clear.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_clear           synchronous clear (new test accepted)
//   i_strobe          a read beat is being acknowledged this edge
//   i_expected        expected read data
//   i_actual          read data from memory
//   i_address         address of the current beat
//   o_err_cnt         saturating mismatch count
//   o_first_err_addr  address of first mismatch
module mem_march_checker
  import mem_march_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_strobe,
  input  logic [WIDTH-1:0]      i_expected,
  input  logic [WIDTH-1:0]      i_actual,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [ERR_WIDTH-1:0]  o_err_cnt,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

  logic                  w_mismatch;
  logic                  w_err_full;
  logic [ERR_WIDTH-1:0]  r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_addr;

  assign w_mismatch = i_strobe && (i_actual != i_expected);
  assign w_err_full = &r_err_cnt;

  // Mismatch counter and first-failing-address latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt    <= '0;
      r_first_addr <= '0;
    end else if (i_clear) begin
      r_err_cnt    <= '0;
      r_first_addr <= '0;
    end else if (w_mismatch) begin
      // Count never wraps, so zero means "no mismatch seen yet".
      if (r_err_cnt == '0) begin
        r_first_addr <= i_address;
      end
      if (!w_err_full) begin
        r_err_cnt <= r_err_cnt + ERR_WIDTH'(1);
      end
    end
  end

  assign o_err_cnt        = r_err_cnt;
  assign o_first_err_addr = r_first_addr;

endmodule

// File: rtl/mem_march_tester.sv
// mem_march_tester
//   BIST initiator running a four-phase march over a single-port
//   valid/ready memory:
//     P0 up: write P   P1 up: read P, write ~P
//     P2 down: read ~P, write P   P3 up: read P
//   Each beat is a full four-phase handshake: valid held until ready
//   is seen high, then valid low until ready is seen low.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start_i                         start request (IDLE/DONE only)
//   addr_o, wr_rd_o, wr_data_o,
//   valid_o                         memory request (all registered)
//   rd_data_i, ready_i              memory response
//   busy_o, done_o, pass_o,
//   timeout_o                       test status
//   err_cnt_o, first_err_addr_o     mismatch count / first failing address
module mem_march_tester
  import mem_march_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 16,
  parameter int               ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] PATTERN    = PAT_BASE[WIDTH-1:0],
  parameter int               TIMEOUT    = 15,
  parameter int               ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  wr_rd_o,
  output logic [WIDTH-1:0]      wr_data_o,
  output logic                  valid_o,
  input  logic [WIDTH-1:0]      rd_data_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ERR_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);
  localparam int                    TMO_W    = $clog2(TIMEOUT + 1);
  // The counter is cleared on state entry, so the TIMEOUT-th waiting edge sees TIMEOUT-1.
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e                r_state, w_state_nxt;
  phase_e                r_phase, w_phase_nxt, w_phase_inc;
  logic                  r_op, w_op_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [TMO_W-1:0]      r_tmo_cnt;
  phase_cfg_t            w_cfg, w_cfg_nxt, w_cfg_inc;
  logic                  w_is_read, w_last_op, w_last_addr, w_tmo_hit;
  logic                  w_tmo_abort, w_start_acc;
  logic [WIDTH-1:0]      w_expected;
  logic [ERR_WIDTH-1:0]  w_err_cnt;
  logic [ADDR_WIDTH-1:0] w_first_addr;

  logic                  r_valid, r_busy, r_done, r_pass, r_timeout, r_wr_rd;
  logic [WIDTH-1:0]      r_wr_data;
  logic                  w_valid_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt, w_timeout_nxt, w_wr_rd_nxt;
  logic [WIDTH-1:0]      w_wr_data_nxt;

  assign w_cfg       = phase_cfg(r_phase);
  assign w_phase_inc = phase_e'(r_phase + 2'd1);
  assign w_cfg_inc   = phase_cfg(w_phase_inc);
  assign w_cfg_nxt   = phase_cfg(w_phase_nxt);
  assign w_is_read   = w_cfg.has_read && !r_op;
  assign w_last_op   = ({1'b0, r_op} == (w_cfg.op_cnt - 2'd1));
  assign w_last_addr = w_cfg.desc ? (r_addr == '0) : (r_addr == ADDR_MAX);
  assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
  assign w_expected  = w_cfg.exp_inv ? ~PATTERN : PATTERN;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus op/address/phase sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_start_acc = 1'b0;
    w_tmo_abort = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_ACCESS;
          w_phase_nxt = PH_P0;
          w_op_nxt    = 1'b0;
          w_addr_nxt  = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ACCESS: begin
        if (ready_i) begin
          w_state_nxt = ST_RELEASE;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_DONE;
          w_tmo_abort = 1'b1;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RELEASE: begin
        if (!ready_i) begin
          // Advance op first, then address, then phase.
          w_state_nxt = ST_ACCESS;
          if (!w_last_op) begin
            w_op_nxt = 1'b1;
          end else begin
            w_op_nxt = 1'b0;
            if (!w_last_addr) begin
              w_addr_nxt = w_cfg.desc ? (r_addr - ADDR_WIDTH'(1)) : (r_addr + ADDR_WIDTH'(1));
            end else if (r_phase == PH_P3) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_phase_nxt = w_phase_inc;
              w_addr_nxt  = w_cfg_inc.desc ? ADDR_MAX : '0;
            end
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_DONE;
          w_tmo_abort = 1'b1;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the next state/phase/op.
  always_comb begin
    w_valid_nxt   = (w_state_nxt == ST_ACCESS);
    w_busy_nxt    = (w_state_nxt == ST_ACCESS) || (w_state_nxt == ST_RELEASE);
    w_done_nxt    = (w_state_nxt == ST_DONE);
    // Request fields only change when a new access is launched, so they stay put while valid.
    w_wr_rd_nxt   = (w_state_nxt == ST_ACCESS) ? !(w_cfg_nxt.has_read && !w_op_nxt) : r_wr_rd;
    w_wr_data_nxt = (w_state_nxt == ST_ACCESS) ? (w_cfg_nxt.wr_inv ? ~PATTERN : PATTERN) : r_wr_data;
    w_timeout_nxt = w_start_acc ? 1'b0 : (r_timeout || w_tmo_abort);
    w_pass_nxt    = w_done_nxt && !w_timeout_nxt && (w_err_cnt == '0);
  end

  // Sequencer registers, handshake timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= PH_P0;
      r_op      <= 1'b0;
      r_addr    <= '0;
      r_tmo_cnt <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_wr_rd   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_op      <= w_op_nxt;
      r_addr    <= w_addr_nxt;
      if (w_state_nxt != r_state) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == ST_ACCESS) || (r_state == ST_RELEASE)) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_timeout <= w_timeout_nxt;
      r_wr_rd   <= w_wr_rd_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  mem_march_checker #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ERR_WIDTH  (ERR_WIDTH)
  ) u_checker (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_clear          (w_start_acc),
    .i_strobe         ((r_state == ST_ACCESS) && ready_i && w_is_read),
    .i_expected       (w_expected),
    .i_actual         (rd_data_i),
    .i_address        (r_addr),
    .o_err_cnt        (w_err_cnt),
    .o_first_err_addr (w_first_addr)
  );

  assign addr_o           = r_addr;
  assign wr_rd_o          = r_wr_rd;
  assign wr_data_o        = r_wr_data;
  assign valid_o          = r_valid;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign timeout_o        = r_timeout;
  assign err_cnt_o        = w_err_cnt;
  assign first_err_addr_o = w_first_addr;

endmodule
